counter_mod_updown: RTL and testbench

- Parametrised successor to the team's loadable enable counter.
- Adds a programmable modulus, up/down direction, and run-time wrap or saturate mode.
- Adds a registered terminal-count pulse and a sticky overflow flag.
- Used as a general event/timer counter in datapath and control blocks; one instance per count channel.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_prescaler.sv | 28 ++
 rtl/counter_mod_updown.sv | 93 +++++++++
 tb/tb_counter_mod_updown.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the counter family.
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Load values above the top of the count range are pinned to that top.
  function automatic int unsigned clamp_to_max(input int unsigned value,
                                               input int unsigned max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides enab pulses by PRESCALE; step_out is high on every PRESCALE-th enab cycle.
module counter_prescaler #(
  parameter int PRESCALE = 4,
  parameter int WIDTH    = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enab,
  output logic step_out
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PRESCALE - 1);

  // Down-counter of enab cycles remaining before the next step.
  logic [WIDTH-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      remaining <= LAST;
    end else if (enab) begin
      remaining <= (remaining == '0) ? LAST : remaining - WIDTH'(1);
    end
  end

  assign step_out = enab && (remaining == '0);

endmodule

// File: rtl/counter_mod_updown.sv
// Modulo up/down counter with wrap/saturate mode, tc pulse and sticky overflow.
// Define COUNTER_PRESCALE_EN to divide enab by PRESCALE before each count step.
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             load,
  input  logic             enab,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  if (WIDTH < 2 || WIDTH > 31 || MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 || PRESCALE < 2)
  begin : g_param_check
    $error("counter_mod_updown: illegal WIDTH/MAX_VAL/PRESCALE");
  end

  logic             step;
  logic [WIDTH-1:0] cnt_nxt;
  logic             tc_nxt;
  logic             ovf_set;
  logic             ovf_nxt;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (load),
    .enab     (enab),
    .step_out (step)
  );
`else
  assign step = enab;
`endif

  always_comb begin
    cnt_nxt = cnt_out;
    tc_nxt  = 1'b0;
    ovf_set = 1'b0;
    if (load) begin
      cnt_nxt = WIDTH'(clamp_to_max(32'(cnt_in), int'(MAX_VAL)));
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (cnt_out == MAX_W) begin
          ovf_set = 1'b1;
          if (sat == MODE_WRAP) begin
            cnt_nxt = '0;
            tc_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_out + WIDTH'(1);
        end
      end else begin
        if (cnt_out == '0) begin
          ovf_set = 1'b1;
          if (sat == MODE_WRAP) begin
            cnt_nxt = MAX_W;
            tc_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_out - WIDTH'(1);
        end
      end
    end
    // A set event on the same edge as clr_ovf keeps the flag high.
    ovf_nxt = ovf_set || (ovf && !clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out <= '0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      cnt_out <= cnt_nxt;
      tc      <= tc_nxt;
      ovf     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Self-checking bench for counter_mod_updown (WIDTH=4, MAX_VAL=9, PRESCALE=3).
module tb_counter_mod_updown;

  localparam int WIDTH    = 4;
  localparam int MAX_VAL  = 9;
  localparam int PRESCALE = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] cnt_in = '0;
  logic             load = 1'b0;
  logic             enab = 1'b0;
  logic             up_dn = 1'b1;
  logic             sat = 1'b0;
  logic             clr_ovf = 1'b0;
  logic [WIDTH-1:0] cnt_out;
  logic             tc;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Reference state kept as plain integers.
  int m_cnt = 0;
  int m_tc  = 0;
  int m_ovf = 0;
  int m_ph  = 0;

  counter_mod_updown #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cnt_in  (cnt_in),
    .load    (load),
    .enab    (enab),
    .up_dn   (up_dn),
    .sat     (sat),
    .clr_ovf (clr_ovf),
    .cnt_out (cnt_out),
    .tc      (tc),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d: got %0d expected %0d", tag, cycle, obs, exp);
    end
  endtask

  function automatic void model_edge(input int r, input int l, input int e, input int u,
                                     input int s, input int c, input int v);
    int stepping;
    int set_ev;
    if (r != 0) begin
      m_cnt = 0; m_tc = 0; m_ovf = 0; m_ph = 0;
    end else if (l != 0) begin
      m_cnt = (v > MAX_VAL) ? MAX_VAL : v;
      m_tc  = 0;
      m_ph  = 0;
      if (c != 0) m_ovf = 0;
    end else begin
      stepping = e;
`ifdef COUNTER_PRESCALE_EN
      if (e != 0) begin
        if (m_ph == PRESCALE - 1) begin
          m_ph = 0;
          stepping = 1;
        end else begin
          m_ph = m_ph + 1;
          stepping = 0;
        end
      end
`endif
      set_ev = 0;
      m_tc   = 0;
      if (stepping != 0) begin
        if (u != 0) begin
          if (m_cnt == MAX_VAL) begin
            set_ev = 1;
            if (s == 0) begin m_cnt = 0; m_tc = 1; end
          end else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin
            set_ev = 1;
            if (s == 0) begin m_cnt = MAX_VAL; m_tc = 1; end
          end else m_cnt = m_cnt - 1;
        end
      end
      if (set_ev != 0) m_ovf = 1;
      else if (c != 0) m_ovf = 0;
    end
  endfunction

  // Apply one cycle of inputs, advance the model, then check just after the edge.
  task automatic cyc(input int r, input int l, input int e, input int u,
                     input int s, input int c, input int v);
    rst = 1'(r); load = 1'(l); enab = 1'(e); up_dn = 1'(u);
    sat = 1'(s); clr_ovf = 1'(c); cnt_in = WIDTH'(v);
    model_edge(r, l, e, u, s, c, v);
    @(posedge clk);
    #1;
    cycle++;
    check_val("cnt_out", int'(cnt_out), m_cnt);
    check_val("tc", int'(tc), m_tc);
    check_val("ovf", int'(ovf), m_ovf);
  endtask

  initial begin
    // Reset dominates load and enab.
    cyc(1, 1, 1, 1, 0, 0, 5);
    cyc(1, 1, 1, 1, 0, 0, 5);
    check_val("reset_cnt", int'(cnt_out), 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);

    // Up wrap from 8.
    cyc(0, 1, 0, 1, 0, 0, 8);
    for (int i = 0; i < 3 * PRESCALE; i++) cyc(0, 0, 1, 1, 0, 0, 0);

    // Down saturate from 1.
    cyc(0, 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3 * PRESCALE; i++) cyc(0, 0, 1, 0, 1, 0, 0);

    // Clamp with load over enab, then clr_ovf colliding with a wrap.
    cyc(0, 1, 1, 1, 0, 0, 15);
    check_val("load_clamp", int'(cnt_out), MAX_VAL);
    for (int i = 0; i < PRESCALE; i++) cyc(0, 0, 1, 1, 0, 1, 0);

    // Direction changes, then a lone clr_ovf.
    cyc(0, 1, 0, 1, 0, 0, 5);
    for (int i = 0; i < 2 * PRESCALE; i++) cyc(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3 * PRESCALE; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check_val("ovf_cleared", int'(ovf), 0);

    // Continuous counting with a load landing mid-phase.
    cyc(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 3);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1, 0, 0, 0);

    // Boundary pile-up: wrap on consecutive steps in both directions.
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 * PRESCALE; i++) cyc(0, 0, 1, i % 2, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0) ? 1 : 0,
          ($urandom_range(0, 7) == 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          int'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 1 : 0,
          ($urandom_range(0, 7) == 0) ? 1 : 0,
          int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
